duty_button_ctrl: RTL and testbench
===================================

// Module: duty_button_ctrl
// PURPOSE
//  Front-end conditioner for the PWM generator's duty-step inputs. Takes two raw asynchronous
//  pushbuttons and produces clean one-cycle increase_duty / decrease_duty step pulses.
//  Per channel: synchronise, debounce, then press-edge pulse plus optional hold auto-repeat.
//  Outputs wire directly to the PWM generator's increase_duty / decrease_duty inputs.
// PARAMETERS
//  DEBOUNCE_CYCLES  16   consecutive synced cycles a new level must persist before acceptance (>=2)
//  REPEAT_EN        1    1: auto-repeat while held; 0: one pulse per press
//  REPEAT_DELAY     64   cycles from the press pulse to the first repeat pulse (>=2)
//  REPEAT_PERIOD    32   cycles between subsequent repeat pulses (>=2)
//  CNT_W            16   counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)
// PORTS
//  clk            in   1  system clock, all logic on posedge
//  rst_n          in   1  synchronous reset, active-low
//  btn_inc_raw    in   1  raw "increase" button, asynchronous, active-high, may bounce
//  btn_dec_raw    in   1  raw "decrease" button, asynchronous, active-high, may bounce
//  increase_duty  out  1  one-cycle step-up pulse to the PWM generator
//  decrease_duty  out  1  one-cycle step-down pulse to the PWM generator
//  inc_held       out  1  debounced level of the increase button
//  dec_held       out  1  debounced level of the decrease button
// BEHAVIOUR
//  Decided: one clock (clk); reset rst_n is synchronous and active-low.
//  - Reset (rst_n=0 at posedge): sync flops, debounced levels, counters and FSMs clear;
//    all four outputs 0 and FSMs to IDLE. No pulses are emitted while rst_n=0.
//  - Sync: 2-flop synchroniser per channel; sync2 follows raw 2 edges later.
//  - Debounce: counter clears whenever sync2 == held. Counter increments while sync2 != held.
//    When the counter reaches DEBOUNCE_CYCLES, held toggles and the counter clears.
//    Any glitch shorter than DEBOUNCE_CYCLES never changes held.
//  - Per-channel FSM, using cnt:
//      IDLE   -> PRESS   when held rises.
//      PRESS  : pulse registered for 1 cycle; cnt=0; -> WAIT   if REPEAT_EN, else -> HOLD.
//      WAIT   : cnt++; at cnt==REPEAT_DELAY-1 -> pulse, cnt=0, -> REPEAT.
//      REPEAT : cnt++; at cnt==REPEAT_PERIOD-1 -> pulse, cnt=0.
//      HOLD/WAIT/REPEAT -> IDLE when held falls (same edge; no pulse on release).
//  - Latency: raw sampled high at edge 0 and stable -> press pulse high in cycle 2+DEBOUNCE_CYCLES+1.
//    This is 19 at the defaults. Repeats then follow at +REPEAT_DELAY, then every +REPEAT_PERIOD.
//  - Pulse width is exactly 1 cycle. increase_duty and decrease_duty are never high together.
//  - Conflict: while both held are 1, both outputs are masked to 0.
//    Any pulse due in that window is dropped, not deferred. FSM timing keeps running.
//    Both rising on the same edge -> both press pulses dropped.
//  - Reset mid-hold: after rst_n returns with a button still down, the press is treated as new.
//    A full sync+debounce follows, then a press pulse at the same 19-cycle latency.
//  - Counters saturate-free by construction: each clears at its terminal value, so no wrap-around.
// TESTING (defaults: DEBOUNCE_CYCLES=16, REPEAT_DELAY=64, REPEAT_PERIOD=32, REPEAT_EN=1)
//  1 Reset: rst_n=0 for 5 cycles with both buttons high -> all outputs 0.
//    Release rst_n, inc still high -> increase_duty pulse 19 cycles after release, width 1.
//  2 btn_inc_raw high cycles 0..39, then low -> exactly one increase_duty pulse at cycle 19.
//    inc_held rises at 18; no further pulses; decrease_duty stays 0.
//  3 btn_dec_raw toggling every 3 cycles for 30 cycles, then low -> no pulse; dec_held stays 0.
//  4 btn_inc_raw high cycles 0..199 -> exactly 6 pulses, at 19, 83, 115, 147, 179, 211.
//    inc_held falls at 218; no pulse after it.
//  5 Both raw rise at cycle 0 and stay high 100 cycles -> zero pulses on either output.
//    Then inc held alone, dec pressed at cycle 50 -> inc repeats stop while both held, resume after dec release.
//  6 REPEAT_EN=0, inc held 300 cycles -> single pulse at 19 only.

Source files
------------

// File: rtl/duty_button_ctrl.sv
// Two-channel pushbutton conditioner: synchronise, debounce, then emit one-cycle
// press and auto-repeat step pulses for the PWM generator's duty inputs.
module duty_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 32,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic increase_duty,
  output logic decrease_duty,
  output logic inc_held,
  output logic dec_held
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_REPEAT = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  logic [1:0] raw;
  logic [1:0] held;
  logic [1:0] pulse;
  logic       both_held;

  assign raw       = {btn_dec_raw, btn_inc_raw};
  assign both_held = held[0] & held[1];

  // Channel 0 is increase, channel 1 is decrease.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic             sync1_reg;
      logic             sync2_reg;
      logic             held_reg;
      logic             pulse_reg;
      logic [CNT_W-1:0] db_cnt_reg;
      logic [CNT_W-1:0] rp_cnt_reg;
      state_t           state_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync1_reg  <= 1'b0;
          sync2_reg  <= 1'b0;
          held_reg   <= 1'b0;
          db_cnt_reg <= '0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == held_reg) begin
            db_cnt_reg <= '0;
          end else if (db_cnt_reg == CNT_W'(DEBOUNCE_CYCLES)) begin
            held_reg   <= ~held_reg;
            db_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + CNT_W'(1);
          end
        end
      end

      // A pulse that falls due while both buttons are held is dropped, but the
      // repeat timing keeps running so the cadence resumes unchanged.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_reg  <= S_IDLE;
          rp_cnt_reg <= '0;
          pulse_reg  <= 1'b0;
        end else begin
          pulse_reg <= 1'b0;
          case (state_reg)
            S_IDLE: begin
              if (held_reg) begin
                pulse_reg  <= ~both_held;
                rp_cnt_reg <= '0;
                state_reg  <= (REPEAT_EN != 0) ? S_WAIT : S_HOLD;
              end
            end
            S_WAIT: begin
              if (!held_reg) begin
                state_reg <= S_IDLE;
              end else if (rp_cnt_reg == CNT_W'(REPEAT_DELAY - 1)) begin
                pulse_reg  <= ~both_held;
                rp_cnt_reg <= '0;
                state_reg  <= S_REPEAT;
              end else begin
                rp_cnt_reg <= rp_cnt_reg + CNT_W'(1);
              end
            end
            S_REPEAT: begin
              if (!held_reg) begin
                state_reg <= S_IDLE;
              end else if (rp_cnt_reg == CNT_W'(REPEAT_PERIOD - 1)) begin
                pulse_reg  <= ~both_held;
                rp_cnt_reg <= '0;
              end else begin
                rp_cnt_reg <= rp_cnt_reg + CNT_W'(1);
              end
            end
            default: begin
              if (!held_reg) begin
                state_reg <= S_IDLE;
              end
            end
          endcase
        end
      end

      assign held[gi]  = held_reg;
      assign pulse[gi] = pulse_reg;
    end
  endgenerate

  assign increase_duty = pulse[0];
  assign decrease_duty = pulse[1];
  assign inc_held      = held[0];
  assign dec_held      = held[1];

endmodule

// File: tb/tb_duty_button_ctrl.sv
// Scoreboard bench for duty_button_ctrl: a window-based reference model predicts
// debounced levels and pulse times; a negedge monitor pops and compares them.
module tb_duty_button_ctrl;

  localparam int D    = 16;
  localparam int DLY  = 64;
  localparam int PER  = 32;
  localparam int MAXN = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_inc_raw = 1'b1;
  logic btn_dec_raw = 1'b1;
  logic inc0, dec0, ih0, dh0;
  logic inc1, dec1, ih1, dh1;

  always #5 clk = ~clk;

  duty_button_ctrl #(.REPEAT_EN(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .btn_inc_raw(btn_inc_raw), .btn_dec_raw(btn_dec_raw),
    .increase_duty(inc0), .decrease_duty(dec0), .inc_held(ih0), .dec_held(dh0)
  );

  duty_button_ctrl #(.REPEAT_EN(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .btn_inc_raw(btn_inc_raw), .btn_dec_raw(btn_dec_raw),
    .increase_duty(inc1), .decrease_duty(dec1), .inc_held(ih1), .dec_held(dh1)
  );

  typedef struct {
    int cyc;
    int ch;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  total = 0;
  int  bad = 0;
  int  edge_idx = -1;
  int  n_len = 0;
  int  scen = 0;
  bit  ri[MAXN];
  bit  rd[MAXN];
  bit  hi[MAXN];
  bit  hd[MAXN];
  bit  pexp[2][MAXN];

  function automatic void chk(bit ok, string name, int act, int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (scenario %0d, edge %0d)", name, act, exp, scen, edge_idx);
    end
  endfunction

  function automatic bit raw_of(int ch, int i);
    if (i < 0) return 1'b0;
    return (ch == 0) ? ri[i] : rd[i];
  endfunction

  function automatic bit held_of(int ch, int i);
    if (i < 0) return 1'b0;
    return (ch == 0) ? hi[i] : hd[i];
  endfunction

  // Held toggles once the raw level has disagreed with it for D+1 consecutive
  // samples (seen two cycles late through the synchroniser). Pulses: press one
  // cycle after held rises, repeats at +DLY then every +PER while held stays up.
  task automatic build_model();
    bit h;
    bit ok;
    int f;
    int t;
    for (int ch = 0; ch < 2; ch++) begin
      h = 1'b0;
      for (int e = 0; e < n_len; e++) begin
        ok = 1'b1;
        for (int j = e - 2 - D; j <= e - 2; j++)
          if (raw_of(ch, j) == h) ok = 1'b0;
        if (ok) h = ~h;
        if (ch == 0) hi[e] = h; else hd[e] = h;
      end
    end
    for (int k = 0; k < 2; k++) begin
      for (int ch = 0; ch < 2; ch++)
        for (int i = 0; i < MAXN; i++) pexp[ch][i] = 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        for (int r = 0; r < n_len; r++) begin
          if (held_of(ch, r) && !held_of(ch, r - 1)) begin
            f = r + 1;
            while (f < n_len && held_of(ch, f)) f++;
            if (r + 1 < n_len) pexp[ch][r + 1] = 1'b1;
            if (k == 0) begin
              t = r + 1 + DLY;
              while (t < n_len && t <= f) begin
                pexp[ch][t] = 1'b1;
                t += PER;
              end
            end
          end
        end
      end
      for (int tt = 1; tt < n_len; tt++) begin
        for (int ch = 0; ch < 2; ch++) begin
          if (pexp[ch][tt] && !(hi[tt - 1] && hd[tt - 1])) begin
            if (k == 0) q0.push_back('{cyc: tt, ch: ch});
            else        q1.push_back('{cyc: tt, ch: ch});
          end
        end
      end
    end
  endtask

  always @(posedge clk) edge_idx <= rst_n ? edge_idx + 1 : -1;

  function automatic void check_pulses(int k, logic pi, logic pd);
    ev_t e;
    bit  have;
    int  got_ch;
    chk(!(pi && pd), "both_pulses_high", int'(pi) + int'(pd), 1);
    if (pi || pd) begin
      got_ch = pi ? 0 : 1;
      have = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
      chk(have, (k == 0) ? "unexpected_pulse_dut0" : "unexpected_pulse_dut1", edge_idx, -1);
      if (have) begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk(e.cyc == edge_idx, (k == 0) ? "pulse_cycle_dut0" : "pulse_cycle_dut1", edge_idx, e.cyc);
        chk(e.ch == got_ch, (k == 0) ? "pulse_chan_dut0" : "pulse_chan_dut1", got_ch, e.ch);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (edge_idx < 0) begin
      chk({inc0, dec0, ih0, dh0} == 4'b0, "reset_outputs_dut0", int'({inc0, dec0, ih0, dh0}), 0);
      chk({inc1, dec1, ih1, dh1} == 4'b0, "reset_outputs_dut1", int'({inc1, dec1, ih1, dh1}), 0);
    end else begin
      chk(ih0 == hi[edge_idx], "inc_held_dut0", int'(ih0), int'(hi[edge_idx]));
      chk(dh0 == hd[edge_idx], "dec_held_dut0", int'(dh0), int'(hd[edge_idx]));
      chk(ih1 == hi[edge_idx], "inc_held_dut1", int'(ih1), int'(hi[edge_idx]));
      chk(dh1 == hd[edge_idx], "dec_held_dut1", int'(dh1), int'(hd[edge_idx]));
      check_pulses(0, inc0, dec0);
      check_pulses(1, inc1, dec1);
    end
  end

  task automatic clear_scen(int n);
    n_len = n;
    for (int i = 0; i < MAXN; i++) begin
      ri[i] = 1'b0;
      rd[i] = 1'b0;
    end
  endtask

  task automatic fill(int ch, int a, int b);
    for (int i = a; i <= b && i < n_len; i++)
      if (ch == 0) ri[i] = 1'b1; else rd[i] = 1'b1;
  endtask

  task automatic fill_random(int ch);
    int  c;
    int  dur;
    bit  lvl;
    c = 0;
    lvl = 1'b0;
    while (c < n_len) begin
      dur = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 150) : $urandom_range(1, 12);
      for (int i = 0; i < dur && c < n_len; i++) begin
        if (ch == 0) ri[c] = lvl; else rd[c] = lvl;
        c++;
      end
      lvl = ~lvl;
    end
  endtask

  // Entered and left in reset with both buttons high, so every scenario also
  // exercises reset masking and a press that is still down when reset lifts.
  task automatic run_scen();
    build_model();
    $display("scenario %0d: len=%0d expected pulses dut0=%0d dut1=%0d", scen, n_len, q0.size(), q1.size());
    repeat (4) @(negedge clk);
    for (int c = 0; c < n_len; c++) begin
      rst_n = 1'b1;
      btn_inc_raw = ri[c];
      btn_dec_raw = rd[c];
      @(negedge clk);
    end
    rst_n = 1'b0;
    btn_inc_raw = 1'b1;
    btn_dec_raw = 1'b1;
    @(negedge clk);
    chk(q0.size() == 0, "missing_pulses_dut0", q0.size(), 0);
    chk(q1.size() == 0, "missing_pulses_dut1", q1.size(), 0);
    q0.delete();
    q1.delete();
    scen++;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    clear_scen(60);  fill(0, 0, 59);                       run_scen();
    clear_scen(100); fill(0, 0, 39);                       run_scen();
    clear_scen(80);
    for (int i = 0; i < 30; i++) rd[i] = ((i / 3) % 2) == 0;
    run_scen();
    clear_scen(260); fill(0, 0, 199);                      run_scen();
    clear_scen(160); fill(0, 0, 99);  fill(1, 0, 99);      run_scen();
    clear_scen(300); fill(0, 0, 249); fill(1, 50, 99);     run_scen();
    clear_scen(330); fill(0, 0, 299);                      run_scen();
    for (int s = 0; s < 8; s++) begin
      clear_scen(350);
      fill_random(0);
      fill_random(1);
      run_scen();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
